// File: rtl/clk_sched_pkg.sv
// Shared types and constants for the clk_sched clock-enable scheduler.
// lim_of() converts a target output frequency into a half-period limit.
package clk_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } chan_state_t;

    localparam int          CNTW     = 32;
    localparam int unsigned SYS_FREQ = 100000000;

    function automatic logic [CNTW-1:0] lim_of(input int unsigned freq);
        return CNTW'(SYS_FREQ / 32'd2 / freq - 32'd1);
    endfunction

endpackage

// File: rtl/clk_sched_chan.sv
// One divider channel of clk_sched: counter, live limit, shadow limit and FSM.
// The FSM state is exported so the top level can derive ready/active from it.
module clk_sched_chan
    import clk_sched_pkg::*;
#(
    parameter int              CNTW      = clk_sched_pkg::CNTW,
    parameter logic [CNTW-1:0] DEF_LIMIT = CNTW'(99999)
) (
    input  logic            clkin,
    input  logic            rstn,
    input  logic            wr,
    input  logic            wr_en,
    input  logic [CNTW-1:0] wr_limit,
    input  logic            sync,
    output logic            clkout,
    output logic            tick,
    output chan_state_t     state
);

    chan_state_t     state_n;
    logic [CNTW-1:0] cnt_q, cnt_n;
    logic [CNTW-1:0] limit_q, limit_n;
    logic [CNTW-1:0] shadow_q, shadow_n;
    logic            clk_n, tick_n, wrap;

    // >= so that a limit lowered below the running count still wraps at once
    assign wrap = (state != IDLE) && (cnt_q >= limit_q);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt_q;
        limit_n  = limit_q;
        shadow_n = shadow_q;
        clk_n    = clkout;
        tick_n   = 1'b0;

        if (state == IDLE) begin
            cnt_n = '0;
            clk_n = 1'b0;
        end else if (sync) begin
            cnt_n = '0;
            clk_n = 1'b0;
            if (state == PEND) begin
                limit_n = shadow_q;
            end
            state_n = (state == STOP) ? IDLE : RUN;
        end else if (wrap) begin
            cnt_n  = '0;
            clk_n  = ~clkout;
            tick_n = 1'b1;
            if (state == PEND) begin
                limit_n = shadow_q;
                state_n = RUN;
            end else if (state == STOP) begin
                clk_n   = 1'b0;
                state_n = IDLE;
            end
        end else begin
            cnt_n = cnt_q + 1'b1;
        end

        // A write is applied on top of this cycle's wrap/sync result.
        if (wr) begin
            if (state == IDLE) begin
                limit_n = wr_limit;
                if (wr_en) begin
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end else if (state == RUN) begin
                if (wr_en) begin
                    shadow_n = wr_limit;
                    state_n  = PEND;
                end else if (!clk_n) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    state_n = STOP;
                end
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt_q    <= '0;
            limit_q  <= DEF_LIMIT;
            shadow_q <= DEF_LIMIT;
            clkout   <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt_q    <= cnt_n;
            limit_q  <= limit_n;
            shadow_q <= shadow_n;
            clkout   <= clk_n;
            tick     <= tick_n;
        end
    end

endmodule

// File: rtl/clk_sched.sv
// Multi-channel clock-enable scheduler with one shared config port.
// Define CLK_SCHED_SYNC_EN to add the sync (phase-realign) input.
module clk_sched
    import clk_sched_pkg::*;
#(
    parameter int              NCH       = 4,
    parameter int              CNTW      = clk_sched_pkg::CNTW,
    parameter logic [CNTW-1:0] DEF_LIMIT = CNTW'(99999),
    localparam int             CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clkin,
    input  logic            rstn,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [CNTW-1:0] cfg_limit,
    input  logic            cfg_en,
`ifdef CLK_SCHED_SYNC_EN
    input  logic            sync,
`endif
    output logic [NCH-1:0]  clkout,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  active
);

    // Handshake: a write is taken on any edge where cfg_valid && cfg_ready;
    // cfg_ready drops only while the addressed channel has an update or stop in flight.
    chan_state_t ch_state [NCH];
    logic        sync_i;
    logic        hs;

`ifdef CLK_SCHED_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i) && (ch_state[i] == PEND || ch_state[i] == STOP)) begin
                cfg_ready = 1'b0;
            end
        end
    end

    assign hs = cfg_valid && cfg_ready;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_sched_chan #(
            .CNTW      (CNTW),
            .DEF_LIMIT (DEF_LIMIT)
        ) u_chan (
            .clkin    (clkin),
            .rstn     (rstn),
            .wr       (hs && (cfg_ch == CHW'(g))),
            .wr_en    (cfg_en),
            .wr_limit (cfg_limit),
            .sync     (sync_i),
            .clkout   (clkout[g]),
            .tick     (tick[g]),
            .state    (ch_state[g])
        );

        assign active[g] = (ch_state[g] != IDLE);
    end

endmodule

// File: tb/tb_clk_sched.sv
// Self-checking bench for clk_sched: event-time model compared every cycle,
// plus directed scenarios whose half-period lengths are pinned by literals.
module tb_clk_sched;
    import clk_sched_pkg::*;

    localparam int NCH = 4;

    logic            clkin = 1'b0;
    logic            rstn  = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [1:0]      cfg_ch = '0;
    logic [31:0]     cfg_limit = '0;
    logic            cfg_en = 1'b0;
    logic            sync_v = 1'b0;
    logic [NCH-1:0]  clkout, tick, active;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit check_en = 0;
    logic [31:0] exp_q[$];

    clk_sched #(.NCH(NCH)) dut (
        .clkin     (clkin),
        .rstn      (rstn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_limit (cfg_limit),
        .cfg_en    (cfg_en),
`ifdef CLK_SCHED_SYNC_EN
        .sync      (sync_v),
`endif
        .clkout    (clkout),
        .tick      (tick),
        .active    (active)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clkin = ~clkin;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- model: absolute toggle times per channel ----------------
    typedef struct {
        bit on;
        bit lvl;
        bit tk;
        int nt;
        int hp;
        bit has_new;
        int hp_new;
        bit stopping;
    } mch_t;

    mch_t m [NCH];
    bit   m_hs;
    int   m_c;

    function automatic bit model_ready(input logic [1:0] ch);
        return !(m[ch].has_new || m[ch].stopping);
    endfunction

    always @(posedge clkin) begin
        cyc++;
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                m[i].on = 0; m[i].lvl = 0; m[i].tk = 0; m[i].nt = 0;
                m[i].hp = 0; m[i].has_new = 0; m[i].hp_new = 0; m[i].stopping = 0;
            end
        end else begin
            m_hs = cfg_valid && model_ready(cfg_ch);
            m_c  = int'(cfg_ch);
            for (int i = 0; i < NCH; i++) begin
                m[i].tk = 0;
                if (m[i].on && sync_v) begin
                    m[i].lvl = 0;
                    if (m[i].stopping) begin
                        m[i].on = 0;
                        m[i].stopping = 0;
                    end else begin
                        if (m[i].has_new) begin
                            m[i].hp = m[i].hp_new;
                            m[i].has_new = 0;
                        end
                        m[i].nt = cyc + m[i].hp;
                    end
                end else if (m[i].on && cyc == m[i].nt) begin
                    m[i].lvl = !m[i].lvl;
                    m[i].tk  = 1;
                    if (m[i].has_new) begin
                        m[i].hp = m[i].hp_new;
                        m[i].has_new = 0;
                    end
                    if (m[i].stopping) begin
                        m[i].lvl = 0;
                        m[i].on = 0;
                        m[i].stopping = 0;
                    end
                    m[i].nt = cyc + m[i].hp;
                end
            end
            if (m_hs) begin
                if (!m[m_c].on) begin
                    if (cfg_en) begin
                        m[m_c].on  = 1;
                        m[m_c].lvl = 0;
                        m[m_c].hp  = int'(cfg_limit) + 1;
                        m[m_c].nt  = cyc + m[m_c].hp;
                    end
                end else if (cfg_en) begin
                    m[m_c].has_new = 1;
                    m[m_c].hp_new  = int'(cfg_limit) + 1;
                end else if (!m[m_c].lvl) begin
                    m[m_c].on = 0;
                end else begin
                    m[m_c].stopping = 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_delta(input string name, input int act);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no expected value queued (got %0d)", name, act);
        end else begin
            chk(name, 64'(act), 64'(exp_q.pop_front()));
        end
    endtask

    logic [NCH-1:0] e_clk, e_tick, e_act;

    always @(negedge clkin) begin
        if (check_en) begin
            for (int i = 0; i < NCH; i++) begin
                e_clk[i]  = m[i].lvl;
                e_tick[i] = m[i].tk;
                e_act[i]  = m[i].on;
            end
            chk("model_clkout", 64'(clkout), 64'(e_clk));
            chk("model_tick", 64'(tick), 64'(e_tick));
            chk("model_active", 64'(active), 64'(e_act));
            chk("model_cfg_ready", 64'(cfg_ready), 64'(model_ready(cfg_ch)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input int ch, input int lim, input bit en, output int t_hs);
        bit done;
        done = 0;
        t_hs = -1;
        @(posedge clkin); #2;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_limit = 32'(lim);
        cfg_en    = en;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clkin);
            if (cfg_ready) begin
                @(posedge clkin); #2;
                t_hs = cyc;
                done = 1;
            end
        end
        cfg_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_timeout ch%0d: cfg_ready never high", ch);
        end
    endtask

    task automatic wait_toggle(input int ch, output int t);
        logic prev;
        bit   seen;
        prev = clkout[ch];
        seen = 0;
        t    = -1;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clkin);
            if (clkout[ch] !== prev) begin
                seen = 1;
                t = cyc;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL toggle_timeout ch%0d: no clkout edge within 400 cycles", ch);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clkin); #2;
        rstn = 1'b0;
        @(posedge clkin); #2;
        rstn = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int th, t0, t1, t2, t3;

        chk("lim_of_500Hz", 64'(lim_of(500)), 64'd99999);
        chk("lim_of_12p5MHz", 64'(lim_of(12500000)), 64'd3);

        @(posedge clkin); #2;
        check_en = 1;
        @(posedge clkin); #2;
        rstn = 1'b1;
        @(negedge clkin);
        chk("reset_clkout", 64'(clkout), 64'd0);
        chk("reset_tick", 64'(tick), 64'd0);
        chk("reset_active", 64'(active), 64'd0);
        chk("reset_cfg_ready", 64'(cfg_ready), 64'd1);

        // ch0 at limit 3: half-period 4 cycles, first toggle limit+1 after handshake
        do_write(0, int'(lim_of(12500000)), 1'b1, th);
        exp_q.push_back(4); exp_q.push_back(4);
        wait_toggle(0, t0);
        expect_delta("ch0_start_latency", t0 - th);
        chk("ch0_active", 64'(active[0]), 64'd1);
        chk("ch0_tick_on_toggle", 64'(tick[0]), 64'd1);
        wait_toggle(0, t1);
        expect_delta("ch0_half_period", t1 - t0);

        // ch0 lowered to limit 1 mid-phase: current half stays 4, later ones are 2
        do_write(0, 1, 1'b1, th);
        @(negedge clkin);
        chk("ch0_ready_pending", 64'(cfg_ready), 64'd0);
        exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(2);
        wait_toggle(0, t2);
        expect_delta("ch0_update_old_half", t2 - t1);
        chk("ch0_ready_after_wrap", 64'(cfg_ready), 64'd1);
        wait_toggle(0, t3);
        expect_delta("ch0_update_new_half_a", t3 - t2);
        wait_toggle(0, t0);
        expect_delta("ch0_update_new_half_b", t0 - t3);

        // ch1 at limit 5 stopped while high: high phase completes, then idle
        do_write(1, 5, 1'b1, th);
        exp_q.push_back(6); exp_q.push_back(6);
        wait_toggle(1, t1);
        expect_delta("ch1_start_latency", t1 - th);
        chk("ch1_high", 64'(clkout[1]), 64'd1);
        do_write(1, 5, 1'b0, th);
        @(negedge clkin);
        chk("ch1_ready_stopping", 64'(cfg_ready), 64'd0);
        chk("ch1_still_high", 64'(clkout[1]), 64'd1);
        wait_toggle(1, t2);
        expect_delta("ch1_full_high_phase", t2 - t1);
        chk("ch1_idle_after_stop", 64'(active[1]), 64'd0);

        // ch2 at limit 100 updated to 10 around cnt=50: old half completes, then 11
        do_write(2, 100, 1'b1, th);
        exp_q.push_back(101); exp_q.push_back(101); exp_q.push_back(11); exp_q.push_back(11);
        wait_toggle(2, t0);
        expect_delta("ch2_start_latency", t0 - th);
        repeat (48) @(posedge clkin);
        do_write(2, 10, 1'b1, th);
        chk("ch2_write_point", 64'(th - t0), 64'd50);
        wait_toggle(2, t1);
        expect_delta("ch2_old_half", t1 - t0);
        wait_toggle(2, t2);
        expect_delta("ch2_new_half_a", t2 - t1);
        wait_toggle(2, t3);
        expect_delta("ch2_new_half_b", t3 - t2);

        // ch3 at limit 0: toggles every cycle, tick always high
        do_write(3, 0, 1'b1, th);
        exp_q.push_back(1); exp_q.push_back(1);
        wait_toggle(3, t0);
        expect_delta("ch3_start_latency", t0 - th);
        wait_toggle(3, t1);
        expect_delta("ch3_half_period", t1 - t0);
        chk("ch3_tick_every_cycle", 64'(tick[3]), 64'd1);

        // reset while channels run and ch0 holds a pending update
        do_write(0, 7, 1'b1, th);
        pulse_reset();
        @(negedge clkin);
        chk("midreset_clkout", 64'(clkout), 64'd0);
        chk("midreset_tick", 64'(tick), 64'd0);
        chk("midreset_active", 64'(active), 64'd0);
        chk("midreset_cfg_ready", 64'(cfg_ready), 64'd1);

        // restart ch0, then stop it while clkout is low: idle at once
        do_write(0, 3, 1'b1, th);
        do_write(0, 3, 1'b0, t0);
        chk("ch0_stop_low_point", 64'(t0 - th), 64'd2);
        @(negedge clkin);
        chk("ch0_stop_low_idle", 64'(active[0]), 64'd0);
        chk("ch0_stop_low_clk", 64'(clkout[0]), 64'd0);

        // idle channel written with en=0 stays idle
        do_write(1, 9, 1'b0, th);
        @(negedge clkin);
        chk("ch1_idle_write", 64'(active[1]), 64'd0);

`ifdef CLK_SCHED_SYNC_EN
        // sync realigns ch0 (limit 2) and ch1 (limit 4): rises 3 and 5 cycles later
        do_write(0, 2, 1'b1, th);
        do_write(1, 4, 1'b1, th);
        repeat (7) @(posedge clkin);
        #2;
        sync_v = 1'b1;
        @(posedge clkin); #2;
        sync_v = 1'b0;
        t0 = cyc;
        @(negedge clkin);
        chk("sync_clkout_low", 64'(clkout[1:0]), 64'd0);
        chk("sync_tick_low", 64'(tick[1:0]), 64'd0);
        exp_q.push_back(3); exp_q.push_back(5);
        wait_toggle(0, t1);
        expect_delta("sync_ch0_rise", t1 - t0);
        wait_toggle(1, t2);
        expect_delta("sync_ch1_rise", t2 - t0);
`endif

        repeat (3) @(posedge clkin);
        #2;
        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
